// File: rtl/fetch_stage_hs.sv
// Instruction-fetch stage: PC register, variable-latency imem req/ack port, valid/ready to decode.
// Optional FETCH_MISALIGN_EN: misaligned PCs are reported on inst_misalign instead of being fetched.
module fetch_stage_hs #(
   parameter int              XLEN     = 32,
   parameter int              PC_STEP  = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
`ifdef FETCH_MISALIGN_EN
   ,
   output logic            inst_misalign
`endif
);

   // state  | meaning
   // S_REQ  | request to memory open (or about to open after reset), waiting for imem_ack
   // S_HOLD | fetched instruction presented to decode, waiting for transfer or redirect

   typedef enum logic {
      S_REQ,
      S_HOLD
   } state_t;

   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_next_q, pc_next_d;
   logic            kill_q, kill_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic            valid_q, valid_d;
   logic            launch;
   logic [XLEN-1:0] launch_pc;
`ifdef FETCH_MISALIGN_EN
   logic            misal_q, misal_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         pc_next_q <= RESET_PC;
         kill_q    <= 1'b0;
         req_q     <= 1'b0;
         inst_q    <= '0;
         inst_pc_q <= '0;
         valid_q   <= 1'b0;
`ifdef FETCH_MISALIGN_EN
         misal_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pc_next_q <= pc_next_d;
         kill_q    <= kill_d;
         req_q     <= req_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         valid_q   <= valid_d;
`ifdef FETCH_MISALIGN_EN
         misal_q   <= misal_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pc_next_d = pc_next_q;
      kill_d    = kill_q;
      req_d     = req_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      valid_d   = valid_q;
      launch    = 1'b0;
      launch_pc = pc_q;
`ifdef FETCH_MISALIGN_EN
      misal_d   = misal_q;
`endif

      case (state_q)
         S_REQ: begin
            if (!req_q) begin
               launch    = 1'b1;
               launch_pc = redirect_valid ? redirect_pc : pc_q;
            end else if (kill_q) begin
               // Killed request: drop the returned word, last redirect wins.
               if (imem_ack) begin
                  kill_d    = 1'b0;
                  launch    = 1'b1;
                  launch_pc = redirect_valid ? redirect_pc : pc_next_q;
               end else if (redirect_valid) begin
                  pc_next_d = redirect_pc;
               end
            end else if (redirect_valid) begin
               if (imem_ack) begin
                  launch    = 1'b1;
                  launch_pc = redirect_pc;
               end else begin
                  // Address must stay stable until the ack, so defer the redirect.
                  kill_d    = 1'b1;
                  pc_next_d = redirect_pc;
               end
            end else if (imem_ack) begin
               state_d   = S_HOLD;
               req_d     = 1'b0;
               inst_d    = imem_rdata;
               inst_pc_d = pc_q;
               valid_d   = 1'b1;
               pc_d      = pc_q + STEP;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               valid_d   = 1'b0;
               launch    = 1'b1;
               launch_pc = redirect_pc;
`ifdef FETCH_MISALIGN_EN
               misal_d   = 1'b0;
`endif
            end else if (valid_q && inst_ready) begin
               valid_d = 1'b0;
`ifdef FETCH_MISALIGN_EN
               // A misaligned PC parks the stage until the next redirect.
               if (!misal_q) begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
               end
               misal_d = 1'b0;
`else
               state_d = S_REQ;
               req_d   = 1'b1;
`endif
            end
         end
         default: state_d = S_REQ;
      endcase

      if (launch) begin
         pc_d    = launch_pc;
         state_d = S_REQ;
         req_d   = 1'b1;
`ifdef FETCH_MISALIGN_EN
         if ((launch_pc % STEP) != '0) begin
            state_d   = S_HOLD;
            req_d     = 1'b0;
            valid_d   = 1'b1;
            inst_d    = '0;
            inst_pc_d = launch_pc;
            misal_d   = 1'b1;
         end
`endif
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = pc_q;
   assign inst_valid = valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
`ifdef FETCH_MISALIGN_EN
   assign inst_misalign = misal_q;
`endif

endmodule
